mul_div_unit: RTL
=================

# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS-subset core. It sits beside the ALU in the execute stage and takes the same two operands (rs → srcA, rt → srcB). Multiply and divide take many cycles, and the unit raises `busy` while one is in progress. The controller stalls the PC on `busy`, and MFHI/MFLO read `hi`/`lo` directly through the writeback mux.

## Interface
Parameters:
- `WIDTH`, default `DATA_WIDTH` (32): operand and HI/LO width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  launches `code`; sampled only in IDLE.
- `code`  in  `MulDivCodePath` (3)  one of MULT, MULTU, DIV, DIVU, MTHI, MTLO. Any other value is a no-op.
- `srcA`  in  `WIDTH`  multiplicand, dividend, or MTHI/MTLO data.
- `srcB`  in  `WIDTH`  multiplier or divisor.
- `flush`  in  1  synchronous abort of an in-flight operation.
- `busy`  out  1  high while in CALC or FIXUP.
- `done`  out  1  one-cycle pulse after HI/LO are updated by a MULT/DIV.
- `hi`  out  `WIDTH`  HI register.
- `lo`  out  `WIDTH`  LO register.

## Operation
- States:
  - IDLE: `start` with a MULT/DIV code goes to CALC.
  - CALC: iteration counter counts WIDTH-1 down to 0, then goes to FIXUP.
  - FIXUP: goes to IDLE.
- At the accepting edge, the unit latches the operands and the signed/unsigned flags, and converts signed operands to magnitudes.
- Multiply is radix-2 shift-add, one multiplier bit per CALC cycle, with a 2·WIDTH accumulator.
- Divide is restoring, one quotient bit per CALC cycle.
- FIXUP applies the signs and writes {hi, lo}:
  - MULT: negate the 64-bit product if sign(A)≠sign(B).
  - DIV: negate the quotient if signs differ; the remainder takes the sign of A.
- Divide by zero (DIV or DIVU, srcB=0): full latency, `lo`=all ones, `hi`=srcA unmodified, no sign fixup.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0 (two's-complement wrap, no trap).
- MTHI/MTLO with `start` in IDLE: write `hi`/`lo` from srcA at that edge. No `busy`, no `done`.
- `start` while busy is ignored.
- `flush` in CALC/FIXUP returns to IDLE next edge; HI/LO are unchanged and `done` is not pulsed.
- `flush` in IDLE overrides `start`: nothing is launched.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- Asserting `rst` mid-operation clears everything immediately and the operation is lost.
- MULT/DIV accepted at edge E0:
  - `busy`=1 from E0 through E33.
  - CALC occupies edges E1..E32.
  - FIXUP writes HI/LO at E33.
  - `busy`=0 and `done`=1 during the cycle after E33.
  - Results are valid from E33 on; latency is 33 cycles.
- The `done` cycle is IDLE, so a new `start` is accepted in that same cycle.
- MTHI/MTLO: 1-cycle latency, value visible after the accepting edge.

## Configuration
- Macro `MUL_DIV_EARLY_OUT_EN`.
- Defined:
  - Multiply leaves CALC early once the remaining unshifted multiplier magnitude bits are all zero; FIXUP follows on the next edge.
  - Minimum MULT latency is 2 cycles (srcB=0).
  - Divide latency is unchanged.
- Undefined: all MULT/DIV operations take exactly 33 cycles.

## Structure
- Package `Types`:
  - `MulDivCodePath` (3 bits).
  - Constants `MUL_DIV_CODE_MULT`, `MULTU`, `DIV`, `DIVU`, `MTHI`, `MTLO`.
  - Constant `MUL_DIV_ITERATIONS` = `DATA_WIDTH`.
- Package `BasicTypes`: `DataPath`, `TRUE`, `FALSE`.
- One combinational sub-module, `mul_div_step`. It performs one shift-add or one restore-subtract iteration on {accumulator, operand}. Keeps the FSM and register file separate from the datapath.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` high exactly one cycle.
- MULT −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 100 / 0 → `lo`=0xFFFFFFFF, `hi`=100; DIV 0x80000000 / −1 → `lo`=0x80000000, `hi`=0.
- MTHI 0x1234 and then MTLO 0x5678 in consecutive cycles → `hi`=0x1234, `lo`=0x5678, `busy` never asserted. Second `start` issued mid-MULT → ignored, first result intact.
- `flush` at cycle 10 of DIVU → `busy` low next cycle, HI/LO hold prior values, no `done`. `rst` low at cycle 5 of MULT → all outputs 0 immediately.
- With `MUL_DIV_EARLY_OUT_EN`: MULTU 5 × 3 → `done` well before cycle 33 with `lo`=15. Without the macro: same operands take exactly 33 cycles.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared data types, mul/div operation codes and FSM states.
//   BasicTypes : DATA_WIDTH, DataPath, TRUE/FALSE
//   Types      : MulDivCodePath, MUL_DIV_CODE_*, MUL_DIV_ITERATIONS, md_state_e
package BasicTypes;
  localparam int DATA_WIDTH = 32;
  typedef logic [DATA_WIDTH-1:0] DataPath;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
endpackage

package Types;
  import BasicTypes::*;
  typedef logic [2:0] MulDivCodePath;
  localparam MulDivCodePath MUL_DIV_CODE_MULT = 3'd0;
  localparam MulDivCodePath MUL_DIV_CODE_MULTU = 3'd1;
  localparam MulDivCodePath MUL_DIV_CODE_DIV = 3'd2;
  localparam MulDivCodePath MUL_DIV_CODE_DIVU = 3'd3;
  localparam MulDivCodePath MUL_DIV_CODE_MTHI = 3'd4;
  localparam MulDivCodePath MUL_DIV_CODE_MTLO = 3'd5;
  localparam int MUL_DIV_ITERATIONS = DATA_WIDTH;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIXUP} md_state_e;
endpackage

// File: rtl/mul_div_step.sv
// mul_div_step: one combinational multiply or divide iteration.
//   is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i   : multiply: running product; divide: {remainder, dividend/quotient}
//   mcand_i : multiply: shifted multiplicand; divide: divisor in the low half
//   mplr_i  : multiply: remaining multiplier bits (unused by divide)
//   acc_o, mcand_o, mplr_o : values after the iteration
module mul_div_step import BasicTypes::*; #(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0]   mplr_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0]   mplr_o
);
  // Partial remainder shifted left with the next dividend bit brought in.
  logic [WIDTH:0]   rs;
  logic             ge;
  logic [WIDTH-1:0] rem_n;
  assign rs = acc_i[2*WIDTH-1:WIDTH-1];
  assign ge = rs >= {1'b0, mcand_i[WIDTH-1:0]};
  // When the trial subtract succeeds the difference is below the divisor, so W bits suffice.
  assign rem_n = ge ? rs[WIDTH-1:0] - mcand_i[WIDTH-1:0] : rs[WIDTH-1:0];
  assign acc_o = is_div ? {rem_n, acc_i[WIDTH-2:0], ge} : acc_i + (mplr_i[0] ? mcand_i : '0);
  assign mcand_o = is_div ? mcand_i : mcand_i << 1;
  assign mplr_o = mplr_i >> 1;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with architectural HI/LO registers.
//   clk, rst (async, active-low)
//   start, code, srcA, srcB : launch MULT/MULTU/DIV/DIVU/MTHI/MTLO (sampled in IDLE)
//   flush : abort an in-flight operation; in IDLE it blocks start
//   busy  : operation in CALC/FIXUP;  done : one-cycle pulse after HI/LO written
//   hi, lo: HI/LO registers
// Option macro MUL_DIV_EARLY_OUT_EN: multiply leaves CALC once the remaining
// multiplier bits are zero.
module mul_div_unit import BasicTypes::*, Types::*; #(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  MulDivCodePath      code,
  input  logic [WIDTH-1:0]   srcA,
  input  logic [WIDTH-1:0]   srcB,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  localparam int CW = $clog2(WIDTH);
  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_s, mcand_s, prod_fix;
  logic [WIDTH-1:0] mplr_q, mplr_d, mplr_s, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic is_div_q, is_div_d, neg_q, neg_d, neg_a_q, neg_a_d, dz_q, dz_d, done_q, done_d;
  logic is_md, sgn, dv, last;
  assign is_md = code inside {MUL_DIV_CODE_MULT, MUL_DIV_CODE_MULTU, MUL_DIV_CODE_DIV, MUL_DIV_CODE_DIVU};
  assign sgn = code == MUL_DIV_CODE_MULT || code == MUL_DIV_CODE_DIV;
  assign dv = code == MUL_DIV_CODE_DIV || code == MUL_DIV_CODE_DIVU;
  assign a_mag = (sgn && srcA[WIDTH-1]) ? -srcA : srcA;
  assign b_mag = (sgn && srcB[WIDTH-1]) ? -srcB : srcB;
  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .is_div(is_div_q), .acc_i(acc_q), .mcand_i(mcand_q), .mplr_i(mplr_q),
    .acc_o(acc_s), .mcand_o(mcand_s), .mplr_o(mplr_s)
  );
`ifdef MUL_DIV_EARLY_OUT_EN
  assign last = cnt_q == '0 || (!is_div_q && mplr_s == '0);
`else
  assign last = cnt_q == '0;
`endif
  assign prod_fix = neg_q ? -acc_q : acc_q;
  // Divide by zero leaves the full dividend magnitude as remainder; restoring the
  // sign of A therefore yields srcA unmodified in HI.
  assign quo_fix = dz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplr_d = mplr_q;
    is_div_d = is_div_q;
    neg_d = neg_q;
    neg_a_d = neg_a_q;
    dz_d = dz_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    if (flush) begin
      state_d = MD_IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start && is_md) begin
            state_d = MD_CALC;
            cnt_d = CW'(WIDTH - 1);
            acc_d = dv ? {{WIDTH{1'b0}}, a_mag} : '0;
            mcand_d = {{WIDTH{1'b0}}, dv ? b_mag : a_mag};
            mplr_d = b_mag;
            is_div_d = dv;
            neg_d = sgn && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
            neg_a_d = sgn && srcA[WIDTH-1];
            dz_d = dv && srcB == '0;
          end
          if (start && code == MUL_DIV_CODE_MTHI) hi_d = srcA;
          if (start && code == MUL_DIV_CODE_MTLO) lo_d = srcA;
        end
        MD_CALC: begin
          acc_d = acc_s;
          mcand_d = mcand_s;
          mplr_d = mplr_s;
          cnt_d = last ? '0 : cnt_q - 1'b1;
          state_d = last ? MD_FIXUP : MD_CALC;
        end
        MD_FIXUP: begin
          state_d = MD_IDLE;
          done_d = 1'b1;
          hi_d = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo_d = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MD_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      mplr_q <= '0;
      is_div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_a_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplr_q <= mplr_d;
      is_div_q <= is_div_d;
      neg_q <= neg_d;
      neg_a_q <= neg_a_d;
      dz_q <= dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != MD_IDLE;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
